cv32e40p_obi_instr_responder: RTL and testbench
===============================================

# cv32e40p_obi_instr_responder

Target-side OBI instruction-bus responder for the core's instruction fetch port. Accepts word fetch requests, reads them from a synchronous-read backing memory, and returns in-order `rvalid`/`rdata`/`err` responses. Response latency is programmable and up to `DEPTH` transactions can be outstanding. Used as the instruction memory model in the core testbench and in FPGA bring-up.

## Interface
Parameters:
- `DEPTH`, 2: maximum outstanding (granted, not yet responded) transactions; range 1..8.
- `MEM_AW`, 16: backing memory word-address width.
- `ADDR_BASE`, 32'h0000_0000: byte base address of the decoded region.
- `ADDR_SIZE`, 32'h0004_0000: byte size of the decoded region.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `instr_req_i`, in, 1: OBI request.
- `instr_addr_i`, in, 32: byte address. Bits [1:0] are ignored.
- `instr_gnt_o`, out, 1: OBI grant. Combinational on `instr_req_i`.
- `instr_rvalid_o`, out, 1: response valid, one cycle per transaction.
- `instr_rdata_o`, out, 32: response data.
- `instr_err_o`, out, 1: response error. Valid with `instr_rvalid_o`.
- `resp_delay_i`, in, 4: extra response latency in cycles, sampled at accept.
- `mem_req_o`, out, 1: backing memory read strobe.
- `mem_addr_o`, out, MEM_AW: backing memory word address.
- `mem_rdata_i`, in, 32: read data, valid the cycle after `mem_req_o`.
- `busy_o`, out, 1: one or more transactions outstanding.
- `stall_en_i`, in, 1: present only with `CV32E40P_OBI_RESP_STALL_EN`.

## Operation
- Occupancy counter `cnt` (0..DEPTH) tracks the number of outstanding transactions.
- `instr_gnt_o = instr_req_i & (cnt < DEPTH) & ~stall`. There is no same-cycle bypass on retire.
- Accept is `instr_req_i & instr_gnt_o`. On accept, a FIFO entry is pushed at the tail with a delay counter loaded from `resp_delay_i`.
- Range check: `(instr_addr_i - ADDR_BASE) < ADDR_SIZE`, computed as 32-bit unsigned with wrap-around subtraction.
  - In range: `mem_req_o=1` in the accept cycle, with `mem_addr_o = off[MEM_AW+1:2]`. The entry captures `mem_rdata_i` on the next cycle, with `err=0`.
  - Out of range: no memory read. The entry holds `rdata=0`, `err=1`, and is marked data-ready immediately.
- Each entry's delay counter decrements every cycle once its data is captured, saturating at 0.
- Retire: the head entry retires when it is data-ready and its counter is 0. In that cycle `instr_rvalid_o=1` and the entry's data/err are driven. At most one retire per cycle; responses are strictly in order.
- When `instr_rvalid_o=0`, `instr_rdata_o` and `instr_err_o` are driven to 0.
- There is no backpressure on responses, because OBI has no rready.
- Accept and retire in the same cycle leave `cnt` unchanged. Accept at `cnt==DEPTH` is impossible because gnt is low.
- `busy_o = (cnt != 0)`.

## Timing
- Reset values: `instr_gnt_o`, `instr_rvalid_o`, `instr_rdata_o`, `instr_err_o`, `mem_req_o`, `mem_addr_o`, and `busy_o` are all 0. The FIFO is empty and `cnt=0`.
- Reset asserted mid-operation discards all outstanding transactions; no response is ever produced for them.
- Accept in cycle N with delay d:
  - In-range: `rvalid` in cycle N+1+d at the earliest.
  - Out-of-range: `rvalid` at N+1+d at the earliest. Data is marked ready at N+1 to keep latency uniform.
- An actual response is produced at `max(own earliest, previous response + 1)`.
- Back-to-back requests with d=0 and DEPTH≥2 sustain one grant and one response per cycle.
- Changing `resp_delay_i` affects only later accepts.

## Configuration
- `CV32E40P_OBI_RESP_STALL_EN` defined:
  - Adds the `stall_en_i` port and a 16-bit Fibonacci LFSR with taps 16,14,13,11 and reset seed 16'hACE1. The LFSR advances every cycle.
  - `stall = stall_en_i & lfsr[0]`.
  - A request held while stalled stays pending. The address must stay stable (initiator obligation); the responder does not check it.
- Undefined: the port and LFSR are absent, `stall=0`, and grant depends only on occupancy.

## Test plan
- Reset, then single fetch: addr 0x100, d=0, mem[0x40]=0x00000013 → gnt same cycle, `mem_addr_o=0x40`, rvalid next cycle with rdata 0x00000013, err 0.
- Back-to-back: 4 fetches 0x0,0x4,0x8,0xC with d=0 → 4 consecutive gnt cycles, 4 consecutive rvalid cycles in order, `busy_o` falls after the last response.
- Out of range: addr 0x0004_0000 with default params, d=2 → no `mem_req_o`, rvalid at N+3 with rdata 0, err 1.
- Full/ordering: DEPTH=2; first fetch with d=5, then second with d=0 → second response at N+7 (one cycle after the first at N+6); third request sees gnt low until the first retires.
- Reset mid-flight: two outstanding, `rst` pulsed → no rvalid afterwards, `cnt=0`, gnt high on next request.
- With macro: `stall_en_i=1`, continuous requests → gnt drops exactly in cycles where `lfsr[0]=1` (matches reference LFSR from seed 0xACE1), and no responses are lost.

Source files
------------

// File: rtl/cv32e40p_obi_instr_responder.sv
// OBI instruction-fetch responder: in-order responses, programmable latency, up to DEPTH outstanding.
// Optional random grant stall when CV32E40P_OBI_RESP_STALL_EN is defined.
module cv32e40p_obi_instr_responder #(
    parameter int          DEPTH     = 2,
    parameter int          MEM_AW    = 16,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] ADDR_SIZE = 32'h0004_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_req_i,
    input  logic [31:0]       instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [31:0]       instr_rdata_o,
    output logic              instr_err_o,
    input  logic [3:0]        resp_delay_i,
    output logic              mem_req_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i,
`ifdef CV32E40P_OBI_RESP_STALL_EN
    input  logic              stall_en_i,
`endif
    output logic              busy_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]      r_data [DEPTH];
    logic [3:0]       r_dly  [DEPTH];
    logic [DEPTH-1:0] r_val;
    logic [DEPTH-1:0] r_rdy;
    logic [DEPTH-1:0] r_err;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW-1:0]    r_cap_idx;
    logic             r_cap_pend;
    logic [CW-1:0]    r_cnt;

    logic [31:0]      w_off;
    logic             w_in_range;
    logic             w_stall;
    logic             w_accept;
    logic             w_head_cap;
    logic             w_retire;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef CV32E40P_OBI_RESP_STALL_EN
    logic [15:0] r_lfsr;
    logic        w_fb;

    // Fibonacci taps 16,14,13,11 in right-shift form
    assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_lfsr <= 16'hACE1;
        else     r_lfsr <= {w_fb, r_lfsr[15:1]};
    end

    assign w_stall = stall_en_i & r_lfsr[0];
`else
    assign w_stall = 1'b0;
`endif

    assign w_off      = instr_addr_i - ADDR_BASE;
    assign w_in_range = (w_off < ADDR_SIZE);
    assign w_accept   = instr_req_i & instr_gnt_o;
    // Head data arriving on mem_rdata_i this cycle counts as ready so d=0 responds at N+1
    assign w_head_cap = r_cap_pend & (r_cap_idx == r_head);
    assign w_retire   = r_val[r_head] & (r_rdy[r_head] | w_head_cap) & (r_dly[r_head] == 4'd0);

    always_comb begin
        instr_gnt_o    = instr_req_i & (r_cnt < CW'(DEPTH)) & ~w_stall;
        mem_req_o      = 1'b0;
        mem_addr_o     = '0;
        instr_rvalid_o = 1'b0;
        instr_rdata_o  = 32'h0;
        instr_err_o    = 1'b0;
        if (w_accept && w_in_range) begin
            mem_req_o  = 1'b1;
            mem_addr_o = w_off[MEM_AW+1:2];
        end
        if (w_retire) begin
            instr_rvalid_o = 1'b1;
            instr_rdata_o  = r_rdy[r_head] ? r_data[r_head] : mem_rdata_i;
            instr_err_o    = r_err[r_head];
        end
    end

    assign busy_o = (r_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val      <= '0;
            r_rdy      <= '0;
            r_err      <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_cap_idx  <= '0;
            r_cap_pend <= 1'b0;
            r_cnt      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= 32'h0;
                r_dly[i]  <= 4'd0;
            end
        end else begin
            r_cap_pend <= w_accept & w_in_range;
            r_cap_idx  <= r_tail;

            for (int i = 0; i < DEPTH; i++) begin
                if (r_val[i] && (r_rdy[i] || (r_cap_pend && r_cap_idx == PW'(i))) && r_dly[i] != 4'd0)
                    r_dly[i] <= r_dly[i] - 4'd1;
                if (r_cap_pend && r_cap_idx == PW'(i)) begin
                    r_data[i] <= mem_rdata_i;
                    r_rdy[i]  <= 1'b1;
                end
            end

            if (w_retire) begin
                r_val[r_head] <= 1'b0;
                r_head        <= f_inc(r_head);
            end

            // Out-of-range entries are born ready with zero data and err set
            if (w_accept) begin
                r_val[r_tail]  <= 1'b1;
                r_rdy[r_tail]  <= ~w_in_range;
                r_err[r_tail]  <= ~w_in_range;
                r_data[r_tail] <= 32'h0;
                r_dly[r_tail]  <= resp_delay_i;
                r_tail         <= f_inc(r_tail);
            end

            if (w_accept && !w_retire)      r_cnt <= r_cnt + CW'(1);
            else if (!w_accept && w_retire) r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_cv32e40p_obi_instr_responder.sv
// Directed bench for cv32e40p_obi_instr_responder with a small synchronous memory model.
module tb_cv32e40p_obi_instr_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic [3:0]  resp_delay_i;
    logic        mem_req_o;
    logic [15:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic        busy_o;
`ifdef CV32E40P_OBI_RESP_STALL_EN
    logic        stall_en_i;
    logic [15:0] ref_lfsr;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] tb_mem [0:255];

    cv32e40p_obi_instr_responder dut (
        .clk            (clk),
        .rst            (rst),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .resp_delay_i   (resp_delay_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_rdata_i    (mem_rdata_i),
`ifdef CV32E40P_OBI_RESP_STALL_EN
        .stall_en_i     (stall_en_i),
`endif
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory; garbage when not read so late/early capture shows up
    always @(posedge clk) begin
        if (mem_req_o) mem_rdata_i <= tb_mem[mem_addr_o[7:0]];
        else           mem_rdata_i <= 32'hDEAD_BEEF;
    end

`ifdef CV32E40P_OBI_RESP_STALL_EN
    always @(posedge clk or posedge rst) begin
        if (rst) ref_lfsr <= 16'hACE1;
        else     ref_lfsr <= {ref_lfsr[0] ^ ref_lfsr[2] ^ ref_lfsr[3] ^ ref_lfsr[5], ref_lfsr[15:1]};
    end
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_req_i = 1'b0;
        instr_addr_i = 32'h0;
        resp_delay_i = 4'd0;
`ifdef CV32E40P_OBI_RESP_STALL_EN
        stall_en_i = 1'b0;
`endif
        step();
        step();
        @(negedge clk);
        n_checks++; if (instr_gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0", instr_gnt_o); end
        n_checks++; if (instr_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", instr_rvalid_o); end
        n_checks++; if (instr_rdata_o !== 32'h0 || instr_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_rdata_err: got %h/%b expected 0/0", instr_rdata_o, instr_err_o); end
        n_checks++; if (mem_req_o !== 1'b0 || mem_addr_o !== 16'h0) begin n_fail++; $display("FAIL reset_mem: got %b/%h expected 0/0", mem_req_o, mem_addr_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single();
        step();
        instr_req_i = 1'b1; instr_addr_i = 32'h100; resp_delay_i = 4'd0;
        @(negedge clk);
        n_checks++; if (instr_gnt_o !== 1'b1) begin n_fail++; $display("FAIL single_gnt: got %b expected 1", instr_gnt_o); end
        n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 16'h40) begin n_fail++; $display("FAIL single_mem: got %b/%h expected 1/0040", mem_req_o, mem_addr_o); end
        n_checks++; if (instr_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL single_rvalid_early: got %b expected 0", instr_rvalid_o); end
        step();
        instr_req_i = 1'b0;
        @(negedge clk);
        n_checks++; if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h0000_0013 || instr_err_o !== 1'b0)
            begin n_fail++; $display("FAIL single_resp: got %b/%h/%b expected 1/00000013/0", instr_rvalid_o, instr_rdata_o, instr_err_o); end
        step();
        @(negedge clk);
        n_checks++; if (instr_rvalid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL single_idle: got rvalid %b busy %b expected 0/0", instr_rvalid_o, busy_o); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            step();
            instr_req_i  = (k < 4);
            instr_addr_i = 32'(k * 4);
            resp_delay_i = 4'd0;
            @(negedge clk);
            if (k < 4) begin
                n_checks++; if (instr_gnt_o !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt[%0d]: got %b expected 1", k, instr_gnt_o); end
            end
            if (k >= 1 && k <= 4) begin
                n_checks++; if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h1000_0000 + 32'(k - 1))
                    begin n_fail++; $display("FAIL b2b_resp[%0d]: got %b/%h expected 1/%h", k, instr_rvalid_o, instr_rdata_o, 32'h1000_0000 + 32'(k - 1)); end
            end
            n_checks++; if (busy_o !== (k >= 1 && k <= 4)) begin n_fail++; $display("FAIL b2b_busy[%0d]: got %b expected %b", k, busy_o, (k >= 1 && k <= 4)); end
        end
        n_checks++; if (instr_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_tail_rvalid: got %b expected 0", instr_rvalid_o); end
    endtask

    task automatic test_out_of_range();
        for (int k = 0; k < 5; k++) begin
            step();
            instr_req_i  = (k == 0);
            instr_addr_i = 32'h0004_0000;
            resp_delay_i = 4'd2;
            @(negedge clk);
            if (k == 0) begin
                n_checks++; if (instr_gnt_o !== 1'b1 || mem_req_o !== 1'b0) begin n_fail++; $display("FAIL oor_accept: got gnt %b memreq %b expected 1/0", instr_gnt_o, mem_req_o); end
            end
            n_checks++; if (instr_rvalid_o !== (k == 3)) begin n_fail++; $display("FAIL oor_rvalid[%0d]: got %b expected %b", k, instr_rvalid_o, (k == 3)); end
            if (k == 3) begin
                n_checks++; if (instr_rdata_o !== 32'h0 || instr_err_o !== 1'b1) begin n_fail++; $display("FAIL oor_resp: got %h/%b expected 0/1", instr_rdata_o, instr_err_o); end
            end
        end
    endtask

    task automatic test_full_ordering();
        logic        exp_gnt;
        logic        exp_rv;
        logic [31:0] exp_rd;
        for (int k = 0; k < 10; k++) begin
            step();
            instr_req_i  = (k <= 7);
            instr_addr_i = (k == 0) ? 32'h10 : (k == 1) ? 32'h14 : 32'h18;
            resp_delay_i = (k == 0) ? 4'd5 : 4'd0;
            exp_gnt = (k <= 1) || (k == 7);
            exp_rv  = (k >= 6 && k <= 8);
            exp_rd  = (k == 6) ? 32'h1000_0004 : (k == 7) ? 32'h1000_0005 : (k == 8) ? 32'h1000_0006 : 32'h0;
            @(negedge clk);
            if (k <= 7) begin
                n_checks++; if (instr_gnt_o !== exp_gnt) begin n_fail++; $display("FAIL full_gnt[%0d]: got %b expected %b", k, instr_gnt_o, exp_gnt); end
            end
            n_checks++; if (instr_rvalid_o !== exp_rv || instr_rdata_o !== exp_rd)
                begin n_fail++; $display("FAIL full_resp[%0d]: got %b/%h expected %b/%h", k, instr_rvalid_o, instr_rdata_o, exp_rv, exp_rd); end
        end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL full_busy_end: got %b expected 0", busy_o); end
    endtask

    task automatic test_reset_midflight();
        for (int k = 0; k < 2; k++) begin
            step();
            instr_req_i = 1'b1; instr_addr_i = 32'h20 + 32'(4 * k); resp_delay_i = 4'd5;
        end
        step();
        instr_req_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (busy_o !== 1'b0 || instr_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_clear: got busy %b rvalid %b expected 0/0", busy_o, instr_rvalid_o); end
        step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            @(negedge clk);
            n_checks++; if (instr_rvalid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_ghost[%0d]: got rvalid %b busy %b expected 0/0", k, instr_rvalid_o, busy_o); end
        end
        step();
        instr_req_i = 1'b1; instr_addr_i = 32'h8; resp_delay_i = 4'd0;
        @(negedge clk);
        n_checks++; if (instr_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt: got %b expected 1", instr_gnt_o); end
        step();
        instr_req_i = 1'b0;
        @(negedge clk);
        n_checks++; if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h1000_0002) begin n_fail++; $display("FAIL rstmid_resp: got %b/%h expected 1/10000002", instr_rvalid_o, instr_rdata_o); end
    endtask

`ifdef CV32E40P_OBI_RESP_STALL_EN
    task automatic test_stall();
        int n_gnt = 0;
        int n_rv  = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            stall_en_i = 1'b1; instr_req_i = 1'b1; instr_addr_i = 32'h0; resp_delay_i = 4'd0;
            @(negedge clk);
            n_checks++; if (instr_gnt_o !== ~ref_lfsr[0]) begin n_fail++; $display("FAIL stall_gnt[%0d]: got %b expected %b", k, instr_gnt_o, ~ref_lfsr[0]); end
            if (instr_gnt_o === 1'b1) n_gnt++;
            if (instr_rvalid_o === 1'b1) n_rv++;
        end
        for (int k = 0; k < 4; k++) begin
            step();
            instr_req_i = 1'b0; stall_en_i = 1'b0;
            @(negedge clk);
            if (instr_rvalid_o === 1'b1) n_rv++;
        end
        n_checks++; if (n_rv != n_gnt) begin n_fail++; $display("FAIL stall_lost: got %0d responses expected %0d", n_rv, n_gnt); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 32'h1000_0000 + 32'(i);
        tb_mem[8'h40] = 32'h0000_0013;
        mem_rdata_i = 32'hDEAD_BEEF;
        test_reset();
        test_single();
        test_back_to_back();
        test_out_of_range();
        test_full_ordering();
        test_reset_midflight();
`ifdef CV32E40P_OBI_RESP_STALL_EN
        test_stall();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
